esp32_prog_bridge: RTL and testbench

ESP32_PROG_BRIDGE -- requirements
Module: esp32_prog_bridge

---
 rtl/esp32_prog_pkg.sv | 26 ++
 rtl/esp32_prog_bridge_sync_2ff.sv | 26 ++
 rtl/esp32_prog_bridge.sv | 145 ++++++++++++++
 tb/tb_esp32_prog_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/esp32_prog_pkg.sv
// Shared types and constants for the ESP32 programming bridge.
// Decoded values are {en, io0}.
package esp32_prog_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // {en, io0}: 01 holds the ESP32 in reset, 10 selects the ROM bootloader, 11 runs
    localparam logic [1:0] DEC_RESET = 2'b01;
    localparam logic [1:0] DEC_BOOT  = 2'b10;
    localparam logic [1:0] DEC_RUN   = 2'b11;

    localparam int unsigned MODE_AUTO  = 0;
    localparam int unsigned MODE_FLASH = 1;

    function automatic logic [1:0] decode_auto(input logic [1:0] dtr_rts);
        case (dtr_rts)
            2'b10:   return DEC_RESET;
            2'b01:   return DEC_BOOT;
            default: return DEC_RUN;
        endcase
    endfunction

endpackage

// File: rtl/esp32_prog_bridge_sync_2ff.sv
// Two-flop synchroniser bank; every bit resets to 1 (idle level of all inputs).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/esp32_prog_bridge.sv
// ESP32 programming bridge: FTDI DTR/RTS to EN/IO0 with a post-reset hold window,
// button readback over the ESP32 SPI lines and a PROGRAMN long-press generator.
module esp32_prog_bridge
    import esp32_prog_pkg::*;
#(
    parameter int unsigned C_mode       = 0,
    parameter int unsigned C_hold_bits  = 17,
    parameter int unsigned C_btn_bits   = 7,
    parameter int unsigned C_spi_bits   = 8,
    parameter int unsigned C_progn_bits = 8
) (
    input  logic                  clk_25mhz,
    input  logic                  reset,
    input  logic                  ftdi_ndtr,
    input  logic                  ftdi_nrts,
    input  logic [C_btn_bits-1:0] btn,
    input  logic                  spi_clk,
    input  logic                  spi_csn,
    output logic                  wifi_en,
    output logic                  wifi_gpio0,
    output logic                  sd_d0_out,
    output logic                  sd_d0_oe,
    output logic                  prog_active,
    output logic                  user_programn
);

    localparam logic [C_hold_bits-1:0] HOLD_MAX = '1;

    logic [3:0] sync_s;
    logic       ndtr_s, nrts_s, sclk_s, csn_s;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk (clk_25mhz),
        .rst (reset),
        .d   ({ftdi_ndtr, ftdi_nrts, spi_clk, spi_csn}),
        .q   (sync_s)
    );

    assign {ndtr_s, nrts_s, sclk_s, csn_s} = sync_s;

    state_t                  state_q, state_d;
    logic [C_hold_bits-1:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]              dec_q, dec_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic [C_spi_bits-1:0]   shift_q, shift_d;
    logic [C_progn_bits-1:0] progn_cnt_q, progn_cnt_d;
    logic                    gpio0_q, gpio0_d;
    logic                    sd_out_q, sd_out_d;
    logic                    sd_oe_q, sd_oe_d;
    logic                    programn_q, programn_d;
    logic                    entry_c;
    logic                    hold_c;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        dec_d       = DEC_RUN;
        sclk_prev_d = sclk_s;
        shift_d     = shift_q;
        progn_cnt_d = '0;
        entry_c     = 1'b0;
        hold_c      = 1'b0;

        if (C_mode == MODE_FLASH) begin
            dec_d = {nrts_s, ndtr_s};
        end else begin
            dec_d = decode_auto({ndtr_s, nrts_s});
        end

        // A fresh entry into the reset code opens (or restarts) the hold window
        entry_c = (C_mode == MODE_AUTO) && (dec_d == DEC_RESET) && (dec_q != DEC_RESET);

        case (state_q)
            IDLE: begin
                if (entry_c) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                if (entry_c) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + C_hold_bits'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        hold_c = (state_d == HOLD);

        // Buttons are parallel-loaded while deselected, shifted out MSB first on SPI clock
        if (csn_s) begin
            shift_d = C_spi_bits'(btn);
        end else if (sclk_s && !sclk_prev_q) begin
            shift_d = {shift_q[C_spi_bits-2:0], 1'b0};
        end

        if (!btn[0] && btn[1]) begin
            progn_cnt_d = progn_cnt_q[C_progn_bits-1] ? progn_cnt_q
                                                      : progn_cnt_q + C_progn_bits'(1);
        end

        gpio0_d    = dec_d[0] & btn[0];
        sd_out_d   = hold_c ? dec_d[0] : shift_d[C_spi_bits-1];
        sd_oe_d    = hold_c | ~csn_s;
        programn_d = ~progn_cnt_d[C_progn_bits-1];
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            dec_q       <= DEC_RUN;
            sclk_prev_q <= 1'b1;
            shift_q     <= '0;
            progn_cnt_q <= '0;
            gpio0_q     <= 1'b1;
            sd_out_q    <= 1'b0;
            sd_oe_q     <= 1'b0;
            programn_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            dec_q       <= dec_d;
            sclk_prev_q <= sclk_prev_d;
            shift_q     <= shift_d;
            progn_cnt_q <= progn_cnt_d;
            gpio0_q     <= gpio0_d;
            sd_out_q    <= sd_out_d;
            sd_oe_q     <= sd_oe_d;
            programn_q  <= programn_d;
        end
    end

    assign wifi_en       = dec_q[1];
    assign wifi_gpio0    = gpio0_q;
    assign sd_d0_out     = sd_out_q;
    assign sd_d0_oe      = sd_oe_q;
    assign prog_active   = (state_q == HOLD);
    assign user_programn = programn_q;

endmodule

// File: tb/tb_esp32_prog_bridge.sv
// Bench for esp32_prog_bridge: one auto-decode and one flash-mode instance,
// both compared every cycle against a pin-history reference model.
module tb_esp32_prog_bridge;

    localparam int unsigned HOLD_BITS = 4;
    localparam int          WIN       = 1 << HOLD_BITS;
    localparam int          PN_SAT    = 128;

    logic       clk_25mhz = 1'b0;
    logic       reset     = 1'b0;
    logic       ftdi_ndtr = 1'b1;
    logic       ftdi_nrts = 1'b1;
    logic [6:0] btn       = 7'h7F;
    logic       spi_clk   = 1'b0;
    logic       spi_csn   = 1'b1;

    logic en0, gp0, sdo0, oe0, pa0, pn0;
    logic en1, gp1, sdo1, oe1, pa1, pn1;
    logic [5:0] obs [2];

    always #20 clk_25mhz = ~clk_25mhz;

    esp32_prog_bridge #(.C_mode(0), .C_hold_bits(HOLD_BITS), .C_btn_bits(7),
                        .C_spi_bits(8), .C_progn_bits(8)) u_dut0 (
        .clk_25mhz(clk_25mhz), .reset(reset), .ftdi_ndtr(ftdi_ndtr), .ftdi_nrts(ftdi_nrts),
        .btn(btn), .spi_clk(spi_clk), .spi_csn(spi_csn),
        .wifi_en(en0), .wifi_gpio0(gp0), .sd_d0_out(sdo0), .sd_d0_oe(oe0),
        .prog_active(pa0), .user_programn(pn0)
    );

    esp32_prog_bridge #(.C_mode(1), .C_hold_bits(HOLD_BITS), .C_btn_bits(7),
                        .C_spi_bits(8), .C_progn_bits(8)) u_dut1 (
        .clk_25mhz(clk_25mhz), .reset(reset), .ftdi_ndtr(ftdi_ndtr), .ftdi_nrts(ftdi_nrts),
        .btn(btn), .spi_clk(spi_clk), .spi_csn(spi_csn),
        .wifi_en(en1), .wifi_gpio0(gp1), .sd_d0_out(sdo1), .sd_d0_oe(oe1),
        .prog_active(pa1), .user_programn(pn1)
    );

    assign obs[0] = {en0, gp0, sdo0, oe0, pa0, pn0};
    assign obs[1] = {en1, gp1, sdo1, oe1, pa1, pn1};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: pin history {ndtr,nrts,sclk,csn}, index 0 = newest edge
    logic [3:0] ph [4];
    int         rem [2];
    logic [7:0] sh;
    int         pn_cnt;
    logic [5:0] exp_o [2];
    string      onames [6] = '{"wifi_en", "wifi_gpio0", "sd_d0_out", "sd_d0_oe",
                               "prog_active", "user_programn"};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [1:0] ref_dec(input int mode, input logic [3:0] p);
        logic [1:0] r;
        if (mode == 1) begin
            r = {p[2], p[3]};
        end else if (p[3] && !p[2]) begin
            r = 2'b01;
        end else if (!p[3] && p[2]) begin
            r = 2'b10;
        end else begin
            r = 2'b11;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ph[i] = 4'hF;
        sh     = 8'h00;
        pn_cnt = 0;
        for (int m = 0; m < 2; m++) begin
            rem[m]   = 0;
            exp_o[m] = 6'b110001;
        end
    endtask

    task automatic model_step();
        logic [1:0] d2, d3;
        logic       act;
        ph[3] = ph[2];
        ph[2] = ph[1];
        ph[1] = ph[0];
        ph[0] = {ftdi_ndtr, ftdi_nrts, spi_clk, spi_csn};
        if (ph[2][0]) sh = {1'b0, btn};
        else if (ph[2][1] && !ph[3][1]) sh = sh << 1;
        if (!btn[0] && btn[1]) pn_cnt = (pn_cnt >= PN_SAT) ? PN_SAT : pn_cnt + 1;
        else pn_cnt = 0;
        for (int m = 0; m < 2; m++) begin
            d2 = ref_dec(m, ph[2]);
            d3 = ref_dec(m, ph[3]);
            if (m == 0 && d2 == 2'b01 && d3 != 2'b01) rem[m] = WIN;
            else if (rem[m] > 0) rem[m] = rem[m] - 1;
            act = (rem[m] > 0);
            exp_o[m] = {d2[1], d2[0] & btn[0], act ? d2[0] : sh[7], act | ~ph[2][0], act,
                        (pn_cnt < PN_SAT)};
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < 6; b++)
                check_eq($sformatf("dut%0d.%s", m, onames[b]), 16'(obs[m][5-b]),
                         16'(exp_o[m][5-b]));
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        model_step();
        @(negedge clk_25mhz);
        check_all();
    endtask

    task automatic set_pins(input logic ndtr, input logic nrts);
        ftdi_ndtr = ndtr;
        ftdi_nrts = nrts;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (n) @(negedge clk_25mhz);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int         first, hi, stage, t, fall;
        logic [7:0] ser;

        #5;
        @(negedge clk_25mhz);
        do_reset(2);
        repeat (5) tick();

        // esptool-style sequence 11 -> 01 -> 10 -> 11
        set_pins(1'b0, 1'b1);
        repeat (10) tick();
        set_pins(1'b1, 1'b0);
        first = -1;
        hi    = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (pa0) begin
                hi++;
                if (first < 0) first = i;
            end
            if (i == 6) set_pins(1'b1, 1'b1);
        end
        check_eq("esp.latency", 16'(first), 16'd3);
        check_eq("esp.width", 16'(hi), 16'(WIN));

        // Retrigger 10 -> 11 -> 10 after eight clocks of HOLD
        set_pins(1'b1, 1'b0);
        hi    = 0;
        stage = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (pa0) hi++;
            if (hi == 8 && stage == 0) begin
                set_pins(1'b1, 1'b1);
                stage = 1;
            end else if (stage == 1) begin
                set_pins(1'b1, 1'b0);
                stage = 2;
            end else if (stage == 2) begin
                set_pins(1'b1, 1'b1);
                stage = 3;
            end
        end
        check_eq("retrig.width", 16'(hi), 16'(8 + 3 + WIN));

        // Button readback, 1 MHz SPI clock
        btn     = 7'b1010101;
        ser     = {1'b0, btn};
        spi_csn = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("rb.bit%0d", i), 16'(sdo0), 16'(ser[7-i]));
            spi_clk = 1'b1;
            repeat (12) tick();
            spi_clk = 1'b0;
            repeat (13) tick();
        end
        spi_csn = 1'b1;
        t = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (!oe0 && t == 0) t = i;
        end
        check_eq("rb.oe_drop", 16'(t), 16'd3);

        // PROGRAMN long press
        btn  = 7'b1111110;
        fall = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (!pn0 && fall < 0) fall = i;
        end
        check_eq("pn.fall", 16'(fall), 16'd128);
        check_eq("pn.held", 16'(pn0), 16'd0);
        btn = 7'b1111100;
        tick();
        check_eq("pn.release", 16'(pn0), 16'd1);

        // Flash mode pass-through
        btn = 7'h7F;
        set_pins(1'b0, 1'b1);
        repeat (5) tick();
        check_eq("m1.gpio0", 16'(gp1), 16'd0);
        check_eq("m1.en", 16'(en1), 16'd1);
        check_eq("m1.active", 16'(pa1), 16'd0);
        set_pins(1'b1, 1'b0);
        repeat (5) tick();
        check_eq("m1.active_rst_code", 16'(pa1), 16'd0);

        // Reset in the middle of a hold window
        set_pins(1'b1, 1'b1);
        repeat (25) tick();
        set_pins(1'b1, 1'b0);
        repeat (8) tick();
        check_eq("rst.mid_hold", 16'(pa0), 16'd1);
        set_pins(1'b1, 1'b1);
        do_reset(2);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pa0) hi++;
        end
        check_eq("rst.no_retrig", 16'(hi), 16'd0);

        // Randomised traffic on all inputs
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0)
                set_pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 15) == 0) spi_csn = ~spi_csn;
            if ($urandom_range(0, 3) == 0) spi_clk = ~spi_clk;
            if ($urandom_range(0, 60) == 0)
                btn = ($urandom_range(0, 1) == 0) ? 7'b1111110 : 7'($urandom);
            if ($urandom_range(0, 999) == 0) do_reset(2);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
